// File: rtl/cp0_int_ctrl_if.sv
// CP0 interrupt-controller bus bundle.
// Groups everything between the pipeline/Compare block (master) and the CP0
// interrupt controller (slave): interrupt sources, the mtc0/mfc0 register port,
// the commit-stage interrupt handshake and eret.
//   timer_int, hw_int            : level interrupt sources
//   count                        : Count register, feeds the Compare block
//   cp0_we/addr/wdata, cp0_rdata : register write strobe and combinational read
//   ex_valid, ex_pc              : interruptible instruction at commit and its PC
//   int_req, int_ack, int_vector : interrupt request, acceptance, handler entry
//   eret, epc                    : exception return and its target
interface cp0_int_ctrl_if;
  logic        timer_int;
  logic [4:0]  hw_int;
  logic [31:0] count;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        int_req;
  logic        int_ack;
  logic [31:0] int_vector;
  logic        eret;
  logic [31:0] epc;

  modport master (
    output timer_int, hw_int, cp0_we, cp0_addr, cp0_wdata, ex_valid, ex_pc, int_ack, eret,
    input  count, cp0_rdata, int_req, int_vector, epc
  );

  modport slave (
    input  timer_int, hw_int, cp0_we, cp0_addr, cp0_wdata, ex_valid, ex_pc, int_ack, eret,
    output count, cp0_rdata, int_req, int_vector, epc
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller.
// Holds Count (9), Status (12), Cause (13) and EPC (14), and runs the interrupt
// handshake with the commit stage: IDLE -> REQ when an enabled interrupt is
// pending and an interruptible instruction is at commit, REQ -> HANDLER on
// int_ack (capturing EPC and setting EXL), HANDLER -> IDLE on eret or a
// software write clearing EXL.
// Ports:
//   clk : clock, all state updates on its rising edge
//   rst : asynchronous active-low reset
//   bus : cp0_int_ctrl_if slave modport (sources, register port, handshake)
module cp0_int_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0180,
  parameter int unsigned COUNT_DIV  = 2
) (
  input logic           clk,
  input logic           rst,
  cp0_int_ctrl_if.slave bus
);

  localparam logic [4:0] AddrCount  = 5'd9;
  localparam logic [4:0] AddrStatus = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;
  localparam logic [7:0] DivLast    = 8'(COUNT_DIV - 1);

  typedef enum logic [1:0] {StIdle, StReq, StHandler} state_e;

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  div_q, div_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [5:0]  ip_hw_q, ip_hw_d;  // {timer, hw_int[4:0]} -> Cause IP[7:2]
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [31:0] epc_q, epc_d;

  logic        wr_count, wr_status, wr_cause, wr_epc;
  logic [31:0] status, cause;
  logic        pending;

  assign wr_count  = bus.cp0_we & (bus.cp0_addr == AddrCount);
  assign wr_status = bus.cp0_we & (bus.cp0_addr == AddrStatus);
  assign wr_cause  = bus.cp0_we & (bus.cp0_addr == AddrCause);
  assign wr_epc    = bus.cp0_we & (bus.cp0_addr == AddrEpc);

  assign status  = {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause   = {16'b0, ip_hw_q, ip_sw_q, 8'b0};
  assign pending = |(cause[15:8] & status[15:8]);

  // Count with prescaler; a software write reloads and restarts the phase.
  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    if (wr_count) begin
      count_d = bus.cp0_wdata;
      div_d   = 8'd0;
    end else if (div_q == DivLast) begin
      count_d = count_q + 32'd1;
      div_d   = 8'd0;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  // Interrupt sources are sampled one cycle before they appear in Cause.
  always_comb begin
    ip_hw_d = {bus.timer_int, bus.hw_int};
    ip_sw_d = ip_sw_q;
    if (wr_cause) begin
      ip_sw_d = bus.cp0_wdata[9:8];
    end
  end

  // Handshake FSM plus Status/EPC next state. Software writes are applied
  // first so hardware EXL/EPC updates from the handshake take priority.
  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    exl_d   = exl_q;
    im_d    = im_q;
    epc_d   = epc_q;

    if (wr_status) begin
      ie_d  = bus.cp0_wdata[0];
      exl_d = bus.cp0_wdata[1];
      im_d  = bus.cp0_wdata[15:8];
    end
    if (wr_epc) begin
      epc_d = bus.cp0_wdata;
    end

    case (state_q)
      StIdle: begin
        if (bus.eret) begin
          exl_d = 1'b0;
        end
        if (pending && ie_q && !exl_q && bus.ex_valid) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.eret) begin
          exl_d = 1'b0;
        end
        // Request is held even if pending drops; only int_ack ends it.
        if (bus.int_ack) begin
          state_d = StHandler;
          exl_d   = 1'b1;
          epc_d   = bus.ex_pc;
        end
      end
      StHandler: begin
        if (bus.eret || (wr_status && !bus.cp0_wdata[1])) begin
          state_d = StIdle;
          exl_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      div_q   <= '0;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      im_q    <= '0;
      ip_hw_q <= '0;
      ip_sw_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      ip_hw_q <= ip_hw_d;
      ip_sw_q <= ip_sw_d;
      epc_q   <= epc_d;
    end
  end

  // Reads return pre-write contents.
  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      AddrCount:  bus.cp0_rdata = count_q;
      AddrStatus: bus.cp0_rdata = status;
      AddrCause:  bus.cp0_rdata = cause;
      AddrEpc:    bus.cp0_rdata = epc_q;
      default:    bus.cp0_rdata = '0;
    endcase
  end

  assign bus.count      = count_q;
  assign bus.int_req    = (state_q == StReq);
  assign bus.int_vector = INT_VECTOR;
  assign bus.epc        = epc_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle against
// a behavioural model of the CP0 registers and interrupt handshake.
module tb_cp0_int_ctrl;
  localparam int unsigned DIV    = 2;
  localparam logic [31:0] VECTOR = 32'h0000_0180;
  localparam int          M_IDLE = 0;
  localparam int          M_REQ  = 1;
  localparam int          M_HND  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cp0_int_ctrl_if bus_if ();

  cp0_int_ctrl #(
    .INT_VECTOR(VECTOR),
    .COUNT_DIV (DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: Count is base + elapsed cycles / DIV.
  logic [31:0] m_base   = '0;
  int unsigned m_ticks  = 0;
  logic [31:0] m_status = '0;
  logic [5:0]  m_ip_hw  = '0;
  logic [1:0]  m_ip_sw  = '0;
  logic [31:0] m_epc    = '0;
  int          m_state  = M_IDLE;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_ticks / DIV);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count();
      5'd12:   return m_status;
      5'd13:   return {16'b0, m_ip_hw, m_ip_sw, 8'b0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [31:0] n_status, n_epc;
  int          n_state;
  logic        wr, pend;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_base   = '0;
      m_ticks  = 0;
      m_status = '0;
      m_ip_hw  = '0;
      m_ip_sw  = '0;
      m_epc    = '0;
      m_state  = M_IDLE;
    end else begin
      wr       = bus_if.cp0_we;
      pend     = |({m_ip_hw, m_ip_sw} & m_status[15:8]);
      n_status = m_status;
      n_epc    = m_epc;
      n_state  = m_state;
      if (wr && bus_if.cp0_addr == 5'd12) n_status = bus_if.cp0_wdata & 32'h0000_FF03;
      if (wr && bus_if.cp0_addr == 5'd14) n_epc = bus_if.cp0_wdata;
      if (m_state == M_IDLE) begin
        if (bus_if.eret) n_status[1] = 1'b0;
        if (pend && m_status[0] && !m_status[1] && bus_if.ex_valid) n_state = M_REQ;
      end else if (m_state == M_REQ) begin
        if (bus_if.eret) n_status[1] = 1'b0;
        if (bus_if.int_ack) begin
          n_state     = M_HND;
          n_status[1] = 1'b1;
          n_epc       = bus_if.ex_pc;
        end
      end else begin
        if (bus_if.eret || (wr && bus_if.cp0_addr == 5'd12 && !bus_if.cp0_wdata[1])) begin
          n_state     = M_IDLE;
          n_status[1] = 1'b0;
        end
      end
      if (wr && bus_if.cp0_addr == 5'd9) begin
        m_base  = bus_if.cp0_wdata;
        m_ticks = 0;
      end else begin
        m_ticks++;
      end
      if (wr && bus_if.cp0_addr == 5'd13) m_ip_sw = bus_if.cp0_wdata[9:8];
      m_ip_hw  = {bus_if.timer_int, bus_if.hw_int};
      m_status = n_status;
      m_epc    = n_epc;
      m_state  = n_state;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("count", bus_if.count, m_count());
    chk("int_req", 32'(bus_if.int_req), 32'(m_state == M_REQ));
    chk("epc", bus_if.epc, m_epc);
    chk("int_vector", bus_if.int_vector, VECTOR);
    chk("rdata", bus_if.cp0_rdata, m_read(bus_if.cp0_addr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus_if.cp0_addr = a;
    #1;
    d = bus_if.cp0_rdata;
  endtask

  task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
    bus_if.cp0_we    = 1'b1;
    bus_if.cp0_addr  = a;
    bus_if.cp0_wdata = d;
    step();
    bus_if.cp0_we = 1'b0;
  endtask

  logic [31:0] r;
  logic        tmr;

  initial begin
    bus_if.timer_int = 1'b0;
    bus_if.hw_int    = '0;
    bus_if.cp0_we    = 1'b0;
    bus_if.cp0_addr  = '0;
    bus_if.cp0_wdata = '0;
    bus_if.ex_valid  = 1'b0;
    bus_if.ex_pc     = '0;
    bus_if.int_ack   = 1'b0;
    bus_if.eret      = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Reset state
    rd(5'd9, r);  chk("rst_count", r, 32'h0);
    rd(5'd12, r); chk("rst_status", r, 32'h0);
    rd(5'd13, r); chk("rst_cause", r, 32'h0);
    step();
    rd(5'd14, r); chk("rst_epc", r, 32'h0);
    chk("rst_int_req", 32'(bus_if.int_req), 32'h0);

    // Count wrap
    cp0_write(5'd9, 32'hFFFF_FFFE);
    rd(5'd9, r); chk("count_loaded", r, 32'hFFFF_FFFE);
    repeat (2) step();
    rd(5'd9, r); chk("count_ffffffff", r, 32'hFFFF_FFFF);
    repeat (2) step();
    rd(5'd9, r); chk("count_wrap", r, 32'h0);

    // Timer interrupt handshake
    bus_if.timer_int = 1'b1;
    bus_if.ex_valid  = 1'b1;
    bus_if.ex_pc     = 32'h0040_0010;
    cp0_write(5'd12, 32'h0000_8001);
    for (int i = 0; i < 2 && !bus_if.int_req; i++) step();
    chk("int_req_rise", 32'(bus_if.int_req), 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("int_req_hold", 32'(bus_if.int_req), 32'h1);
    end
    bus_if.int_ack = 1'b1;
    step();
    bus_if.int_ack = 1'b0;
    chk("epc_capture", bus_if.epc, 32'h0040_0010);
    rd(5'd12, r); chk("status_exl", r, 32'h0000_8003);
    chk("model_status_exl", m_read(5'd12), 32'h0000_8003);
    chk("int_req_after_ack", 32'(bus_if.int_req), 32'h0);

    // No new request in HANDLER; eret re-arms
    for (int i = 0; i < 3; i++) begin
      step();
      chk("handler_quiet", 32'(bus_if.int_req), 32'h0);
    end
    bus_if.eret = 1'b1;
    step();
    bus_if.eret = 1'b0;
    rd(5'd12, r); chk("eret_status", r, 32'h0000_8001);
    step();
    chk("int_req_reassert", 32'(bus_if.int_req), 32'h1);

    // Status write coincident with int_ack: hardware EXL wins
    bus_if.int_ack   = 1'b1;
    bus_if.cp0_we    = 1'b1;
    bus_if.cp0_addr  = 5'd12;
    bus_if.cp0_wdata = 32'h0;
    step();
    bus_if.int_ack = 1'b0;
    bus_if.cp0_we  = 1'b0;
    rd(5'd12, r); chk("ack_vs_write", r, 32'h0000_0002);
    chk("model_ack_vs_write", m_read(5'd12), 32'h0000_0002);
    bus_if.eret      = 1'b1;
    bus_if.timer_int = 1'b0;
    step();
    bus_if.eret = 1'b0;

    // IM masking of hw_int[0]
    bus_if.hw_int = 5'b00001;
    cp0_write(5'd12, 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("im_masked", 32'(bus_if.int_req), 32'h0);
    end
    rd(5'd13, r); chk("cause_hw0", r, 32'h0000_0400);
    cp0_write(5'd12, 32'h0000_0401);
    for (int i = 0; i < 2 && !bus_if.int_req; i++) step();
    chk("im_unmasked", 32'(bus_if.int_req), 32'h1);

    // Asynchronous reset during REQ
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async_int_req", 32'(bus_if.int_req), 32'h0);
    rd(5'd9, r);  chk("rst_async_count", r, 32'h0);
    rd(5'd12, r); chk("rst_async_status", r, 32'h0);
    rd(5'd13, r); chk("rst_async_cause", r, 32'h0);
    rd(5'd14, r); chk("rst_async_epc", r, 32'h0);
    step();
    bus_if.hw_int   = '0;
    bus_if.ex_valid = 1'b0;
    rst = 1'b1;
    step();

    // Randomized traffic
    tmr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) tmr = ~tmr;
      bus_if.timer_int = tmr;
      if ($urandom_range(0, 9) == 0) bus_if.hw_int = 5'($urandom);
      bus_if.cp0_we = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 6))
        0:       bus_if.cp0_addr = 5'd9;
        1, 2:    bus_if.cp0_addr = 5'd12;
        3:       bus_if.cp0_addr = 5'd13;
        4:       bus_if.cp0_addr = 5'd14;
        default: bus_if.cp0_addr = 5'($urandom);
      endcase
      bus_if.cp0_wdata = $urandom;
      if (bus_if.cp0_addr == 5'd12) begin
        bus_if.cp0_wdata[0] = ($urandom_range(0, 3) != 0);
        bus_if.cp0_wdata[1] = ($urandom_range(0, 3) == 0);
      end
      if (bus_if.cp0_addr == 5'd9 && $urandom_range(0, 1) == 0)
        bus_if.cp0_wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      bus_if.ex_valid = ($urandom_range(0, 3) != 0);
      bus_if.ex_pc    = $urandom;
      bus_if.int_ack  = ($urandom_range(0, 2) == 0);
      bus_if.eret     = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 799) != 0);
      step();
    end
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_int_ctrl.md
CP0_INT_CTRL -- requirements
Module: cp0_int_ctrl

Interface
REQ-001 Parameter: INT_VECTOR, 32'h0000_0180, handler entry address driven on int_vector.
REQ-002 Parameter: COUNT_DIV, 2, clk cycles per Count increment (legal range 1..255).
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: timer_int  input  1  level timer interrupt from the Compare block.
REQ-006 Port: hw_int  input  5  level external interrupt lines.
REQ-007 Port: count  output  32  current Count register value, feeds the Compare block.
REQ-008 Port: cp0_we  input  1  CP0 write strobe (mtc0).
REQ-009 Port: cp0_addr  input  5  CP0 register number for read and write.
REQ-010 Port: cp0_wdata  input  32  write data.
REQ-011 Port: cp0_rdata  output  32  combinational read data for cp0_addr.
REQ-012 Port: ex_valid  input  1  commit stage holds an interruptible instruction.
REQ-013 Port: ex_pc  input  32  PC of that instruction.
REQ-014 Port: int_req  output  1  interrupt request to pipeline.
REQ-015 Port: int_ack  input  1  pipeline accepts request and flushes this cycle.
REQ-016 Port: int_vector  output  32  constant INT_VECTOR.
REQ-017 Port: eret  input  1  eret committing this cycle.
REQ-018 Port: epc  output  32  EPC register value, eret return target.

Function
REQ-019 Registers SHALL map as: 9 Count, 12 Status, 13 Cause, 14 EPC; any other address SHALL read 0 and ignore writes.
REQ-020 Count SHALL increment by 1 every COUNT_DIV cycles and wrap 32'hFFFF_FFFF -> 0.
REQ-021 A Count write SHALL load cp0_wdata and restart the divider phase at 0; write beats increment in the same cycle.
REQ-022 Status SHALL implement IE bit 0, EXL bit 1 and IM bits 15:8; other bits SHALL read 0.
REQ-023 Cause IP[7] SHALL be timer_int and IP[6:2] SHALL be hw_int, each registered one cycle; IP[1:0] SHALL be software-writable; ExcCode bits 6:2 SHALL read 0; other bits SHALL read 0.
REQ-024 pending SHALL equal |(Cause[15:8] & Status[15:8]).
REQ-025 The FSM SHALL have the states IDLE, REQ and HANDLER, with reset state IDLE.
REQ-026 IDLE -> REQ SHALL occur when pending & IE & ~EXL & ex_valid.
REQ-027 In REQ, int_req SHALL be 1 and held until int_ack, even if pending drops.
REQ-028 REQ -> HANDLER SHALL occur on int_ack, and that edge SHALL capture EPC <= ex_pc and EXL <= 1.
REQ-029 In HANDLER, eret or a software write clearing EXL SHALL set EXL <= 0 and move the FSM to IDLE.
REQ-030 In HANDLER, a new interrupt SHALL NOT be raised.
REQ-031 eret in IDLE or REQ SHALL clear EXL only; it SHALL NOT change state.
REQ-032 When int_ack or eret coincides with a Status write, the hardware EXL update SHALL win and the remaining bits SHALL come from cp0_wdata.
REQ-033 int_ack while not in REQ SHALL be ignored.
REQ-034 A software EPC write SHALL take effect unless int_ack arrives in the same cycle; in that case ex_pc SHALL win.
REQ-035 cp0_rdata SHALL reflect register contents before the current cycle's write.

Reset
REQ-036 On rst low, Count, Status, Cause, EPC and the divider SHALL be 0, the FSM SHALL be IDLE and int_req SHALL be 0, all immediately and independent of clk.
REQ-037 Reset asserted mid-handshake (REQ or HANDLER) SHALL abort the handshake with no EPC capture.

Verification
REQ-038 Bench SHALL cover: COUNT_DIV=2, Count written 32'hFFFF_FFFE -> reads FFFF_FFFF after 2 cycles, then 0 after 2 more.
REQ-039 Bench SHALL cover: Status=32'h0000_8001, timer_int=1, ex_valid=1, ex_pc=32'h0040_0010, int_ack 3 cycles later -> int_req rises within 2 cycles, holds until ack, then EPC=0040_0010, Status=0000_8003, int_req=0.
REQ-040 Bench SHALL cover: in HANDLER with timer_int still 1 -> int_req stays 0; eret -> IDLE, then int_req re-asserts.
REQ-041 Bench SHALL cover: Status write 32'h0000_0000 in the same cycle as int_ack -> EXL=1, IE=0, IM=0.
REQ-042 Bench SHALL cover: hw_int[0]=1 with IM[2]=0 -> no int_req; set IM[2]=1 -> int_req asserts.
REQ-043 Bench SHALL cover: rst low during REQ -> int_req=0 immediately, all registers read 0.
